// File: rtl/display_scanner_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner:
// scan states and active-high {g,f,e,d,c,b,a} hex glyphs.
package display_scanner_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } state_e;

  // Bit positions inside a {g,f,e,d,c,b,a} segment vector
  localparam int SEG_A = 0;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

endpackage

// File: rtl/display_scanner_hex_to_seven_seg.sv
// Combinational nibble to active-high {g,f,e,d,c,b,a} decoder.
// Output polarity is left to the instantiating scanner.
module hex_to_seven_seg
  import display_scanner_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_nib)
      4'h0: o_seg = GLYPH_0;
      4'h1: o_seg = GLYPH_1;
      4'h2: o_seg = GLYPH_2;
      4'h3: o_seg = GLYPH_3;
      4'h4: o_seg = GLYPH_4;
      4'h5: o_seg = GLYPH_5;
      4'h6: o_seg = GLYPH_6;
      4'h7: o_seg = GLYPH_7;
      4'h8: o_seg = GLYPH_8;
      4'h9: o_seg = GLYPH_9;
      4'hA: o_seg = GLYPH_A;
      4'hB: o_seg = GLYPH_B;
      4'hC: o_seg = GLYPH_C;
      4'hD: o_seg = GLYPH_D;
      4'hE: o_seg = GLYPH_E;
      4'hF: o_seg = GLYPH_F;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// Tick-driven digit scanner with frame-boundary double buffering.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                  clockIn,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [4*DIGITS-1:0]   valueIn,
  input  logic                  load,
  output logic                  loadAck,
  output logic                  frameDone,
  output logic [DIGITS-1:0]     anodes,
  output logic [6:0]            segments
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_POL = {DIGITS{ACTIVE_LOW_AN}};
  localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW_SEG}};

  state_e r_state;
  state_e w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nxt;
  logic [VW-1:0] r_shadow;
  logic [VW-1:0] w_shadow_nxt;
  logic [VW-1:0] r_pend_val;
  logic r_pend;
  logic w_wrap;
  logic w_commit;
  logic w_blank;
  logic [3:0] w_nib;
  logic [6:0] w_glyph;
  logic [DIGITS-1:0] w_an;

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) r_state <= BLANK;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wrap      = 1'b0;
    if (tick) begin
      unique case (r_state)
        BLANK: w_state_nxt = SCAN;
        SCAN: begin
          w_wrap    = (r_idx == LAST);
          w_idx_nxt = w_wrap ? '0 : r_idx + 1'b1;
        end
      endcase
    end
  end

  // Same-cycle load at a wrap bypasses the pending register
  always_comb begin
    w_commit     = w_wrap & (load | r_pend);
    w_shadow_nxt = r_shadow;
    if (w_commit) w_shadow_nxt = load ? valueIn : r_pend_val;
  end

  assign w_nib = w_shadow_nxt[4*int'(w_idx_nxt) +: 4];
  assign w_an  = DIGITS'(1) << w_idx_nxt;

  always_comb begin
    w_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 1; k < DIGITS; k++) begin
      if (int'(w_idx_nxt) == k && (w_shadow_nxt >> (4*k)) == '0)
        w_blank = 1'b1;
    end
`endif
  end

  hex_to_seven_seg u_dec (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      r_idx      <= '0;
      r_shadow   <= '0;
      r_pend_val <= '0;
      r_pend     <= 1'b0;
      loadAck    <= 1'b0;
      frameDone  <= 1'b0;
      anodes     <= AN_POL;
      segments   <= SEG_POL;
    end else begin
      r_idx     <= w_idx_nxt;
      r_shadow  <= w_shadow_nxt;
      loadAck   <= w_commit;
      frameDone <= w_wrap;
      if (w_commit) begin
        r_pend <= 1'b0;
      end else if (load) begin
        r_pend_val <= valueIn;
        r_pend     <= 1'b1;
      end
      if (tick) begin
        anodes   <= w_an ^ AN_POL;
        segments <= (w_blank ? SEG_OFF : w_glyph) ^ SEG_POL;
      end
    end
  end

endmodule
